// File: rtl/median_pkg.sv
// median_pkg: image geometry defaults and pixel/window types shared by the window streamer and the median filter stage
package median_pkg;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;
  localparam int PIX_W_DEF = 8;
  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef pixel_t [8:0] window_t;
endpackage

// File: rtl/median_window_streamer_line_buffer.sv
// line_buffer: one image row of pixels, synchronous write, combinational read at the same index
//   clk/rst_n : clock, async active-low clear of all entries
//   we, idx   : write enable and column index (read and write share it)
//   wdata     : pixel written at idx on the rising edge when we=1
//   rdata     : pixel currently stored at idx
module line_buffer
  import median_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int W = PIX_W_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end
  assign rdata = mem_q[idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '0;
    else mem_q <= mem_d;
endmodule

// File: rtl/median_window_streamer.sv
// median_window_streamer: turns a raster pixel stream into interior 3x3 windows with centre coordinates
//   in_valid/in_ready/in_pixel : raster-order pixel input, in_ready = !win_valid || win_ready
//   win_valid/win_ready        : window output handshake
//   win                        : byte k = pixel[r-1+k/3][c-1+k%3], k=0 in the LSBs
//   win_row/win_col            : window centre coordinates
//   frame_done                 : one-cycle pulse after the last pixel of a frame is accepted
module median_window_streamer
  import median_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*PIX_W-1:0] win,
  output logic [RW-1:0]      win_row,
  output logic [CW-1:0]      win_col,
  output logic               frame_done
);
  logic [CW-1:0] col_q, col_d, win_col_q, win_col_d;
  logic [RW-1:0] row_q, row_d, win_row_q, win_row_d;
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic accept, emit, last_col, last_row;
  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last_row = row_q == RW'(IMG_H - 1);
  // the row/col gates keep stale line-buffer rows and previous-row columns out of the output
  assign emit     = accept && row_q >= RW'(2) && col_q >= CW'(2);
  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .we(accept), .idx(col_q), .wdata(in_pixel), .rdata(lb1_rd)
  );
  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .we(accept), .idx(col_q), .wdata(lb1_rd), .rdata(lb2_rd)
  );
  always_comb begin
    col_d        = accept ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d        = (accept && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    // shift each row left by one column; new right column is {lb2, lb1, pixel} top to bottom
    win_d        = accept ? {in_pixel, win_q[8:7], lb1_rd, win_q[5:4], lb2_rd, win_q[2:1]} : win_q;
    win_valid_d  = accept ? emit : (win_ready ? 1'b0 : win_valid_q);
    win_row_d    = emit ? row_q - RW'(1) : win_row_q;
    win_col_d    = emit ? col_q - CW'(1) : win_col_q;
    frame_done_d = accept && last_col && last_row;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  assign win_valid  = win_valid_q;
  assign win        = win_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;
endmodule
